spi_slave_responder: RTL and testbench

//  SPI responder (target end) for the SoC SPI masters: receives MOSI bytes, returns MISO bytes.

---
 rtl/spi_slave_pkg.sv | 13 +
 rtl/spi_rx_fifo.sv | 53 +++++
 rtl/spi_slave_responder.sv | 208 ++++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and default constants for the SPI responder.
package spi_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int         DEFAULT_DATA_W     = 8;
    localparam int         DEFAULT_RX_DEPTH   = 4;
    localparam logic [7:0] DEFAULT_DUMMY_BYTE = 8'hFF;

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead synchronous FIFO for received SPI words.
module spi_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic              dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);
    assign dropped  = push && !do_push;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/spi_slave_responder.sv
// Mode-0 MSB-first SPI target: oversampled pins, RX FIFO, single TX holding register.
module spi_slave_responder
    import spi_slave_pkg::*;
#(
    parameter int                DATA_W     = DEFAULT_DATA_W,
    parameter int                RX_DEPTH   = DEFAULT_RX_DEPTH,
    parameter logic [DATA_W-1:0] DUMMY_BYTE = DATA_W'(DEFAULT_DUMMY_BYTE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              rx_overrun,
    output logic              tx_underrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_n_p0, cs_n_p1, cs_n_p2;
    logic mosi_p0, mosi_p1;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    state_e            state, next_state;
    logic              word_start;
    logic              do_sample;
    logic              do_shift;
    logic              word_done;
    logic [CNT_W-1:0]  bit_cnt;

    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] rx_word;
    logic              rx_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_dropped;

    logic [DATA_W-1:0] shifter;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] hold;

    // Stage p0..p2: pin synchronisers; edges are taken between p1 and p2.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_n_p0 <= 1'b1;
            cs_n_p1 <= 1'b1;
            cs_n_p2 <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_n_p0 <= cs_n;
            cs_n_p1 <= cs_n_p0;
            cs_n_p2 <= cs_n_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign sclk_rise = sclk_p1 && !sclk_p2;
    assign sclk_fall = !sclk_p1 && sclk_p2;
    assign cs_fall   = !cs_n_p1 && cs_n_p2;
    assign cs_rise   = cs_n_p1 && !cs_n_p2;
    assign word_done = (bit_cnt == CNT_W'(DATA_W));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        word_start = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    next_state = ACTIVE;
                    word_start = 1'b1;
                end
            end
            ACTIVE: begin
                // Deselect wins over any sclk edge seen in the same cycle.
                if (cs_rise) begin
                    next_state = IDLE;
                end else if (sclk_rise && !word_done) begin
                    do_sample = 1'b1;
                end else if (sclk_fall) begin
                    if (word_done) begin
                        word_start = 1'b1;
                    end else begin
                        do_shift = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy    = (state == ACTIVE);
    assign miso_oe = (state == ACTIVE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (word_start || next_state == IDLE) begin
            bit_cnt <= '0;
        end else if (do_sample) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign rx_word = {rx_shift, mosi_p1};
    assign rx_push = do_sample && (bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clock) begin
        if (do_sample) begin
            rx_shift <= rx_word[DATA_W-2:0];
        end
    end

    spi_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RX_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_word),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .dropped   (fifo_dropped)
    );

    assign rx_valid = !fifo_empty;

    always_comb begin
        shift_next = shifter;
        if (word_start) begin
            shift_next = tx_ready ? DUMMY_BYTE : hold;
        end else if (do_shift) begin
            shift_next = {shifter[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        shifter <= shift_next;
    end

    // miso follows the post-update shifter so the new bit is on the pin one cycle sooner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miso <= 1'b0;
        end else begin
            miso <= (next_state == ACTIVE) ? shift_next[DATA_W-1] : 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!(word_start && !tx_ready) && tx_valid && tx_ready) begin
            hold <= tx_data;
        end
    end

    // Word start reads the old holding content; a same-cycle load is kept for the next word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_ready <= 1'b1;
        end else if (word_start && !tx_ready) begin
            tx_ready <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            tx_ready <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            tx_underrun <= word_start && tx_ready;
            rx_overrun  <= fifo_dropped;
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: behavioural SPI master plus queue-based expectation model.
module tb_spi_slave_responder;

    localparam int DATA_W   = 8;
    localparam int RX_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        rx_overrun;
    logic        tx_underrun;

    int n_vec = 0;
    int n_err = 0;
    int ovr_cnt = 0;
    int und_cnt = 0;

    logic [7:0] tx_q[$];
    logic [7:0] frame_q[$];
    logic [7:0] miso_cap[$];
    logic [7:0] got_rx[$];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rx_overrun)  ovr_cnt++;
        if (tx_underrun) und_cnt++;
    end

    spi_slave_responder #(
        .DATA_W     (DATA_W),
        .RX_DEPTH   (RX_DEPTH),
        .DUMMY_BYTE (8'hFF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .busy        (busy),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun)
    );

    // One system clock; also feeds queued TX words through the valid/ready handshake.
    task automatic tick();
        logic acc;
        acc = tx_valid && tx_ready;
        @(posedge clock);
        #1;
        if (acc && tx_q.size() > 0) void'(tx_q.pop_front());
        if (tx_q.size() > 0) begin
            tx_valid = 1'b1;
            tx_data  = tx_q[0];
        end else begin
            tx_valid = 1'b0;
        end
    endtask

    // Mode-0 master at sclk = clock/8; last fall coincides with deselect.
    task automatic send_frame();
        logic [7:0] cap;
        miso_cap.delete();
        repeat (4) tick();
        cs_n = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < frame_q.size(); i++) begin
            cap = 8'h00;
            for (int b = 7; b >= 0; b--) begin
                mosi = frame_q[i][b];
                repeat (4) tick();
                sclk = 1'b1;
                cap  = {cap[6:0], miso};
                repeat (4) tick();
                sclk = 1'b0;
                if (i == frame_q.size() - 1 && b == 0) cs_n = 1'b1;
            end
            miso_cap.push_back(cap);
        end
        repeat (8) tick();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        got_rx.delete();
        while (rx_valid && guard < 16) begin
            got_rx.push_back(rx_data);
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
            guard++;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_vec++; if (miso !== 1'b0)        begin n_err++; $display("FAIL reset_miso got %b exp 0", miso); end
        n_vec++; if (miso_oe !== 1'b0)     begin n_err++; $display("FAIL reset_miso_oe got %b exp 0", miso_oe); end
        n_vec++; if (tx_ready !== 1'b1)    begin n_err++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
        n_vec++; if (rx_valid !== 1'b0)    begin n_err++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (rx_overrun !== 1'b0)  begin n_err++; $display("FAIL reset_rx_overrun got %b exp 0", rx_overrun); end
        n_vec++; if (tx_underrun !== 1'b0) begin n_err++; $display("FAIL reset_tx_underrun got %b exp 0", tx_underrun); end
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_basic();
        int u0;
        u0 = und_cnt;
        tx_q.push_back(8'hA5);
        frame_q = {8'h3C};
        send_frame();
        n_vec++; if (miso_cap[0] !== 8'hA5) begin n_err++; $display("FAIL basic_miso got %h exp a5", miso_cap[0]); end
        n_vec++; if (tx_ready !== 1'b1)     begin n_err++; $display("FAIL basic_tx_ready got %b exp 1", tx_ready); end
        n_vec++; if (und_cnt - u0 != 0)     begin n_err++; $display("FAIL basic_underrun got %0d exp 0", und_cnt - u0); end
        drain();
        n_vec++; if (got_rx.size() != 1)    begin n_err++; $display("FAIL basic_rx_count got %0d exp 1", got_rx.size()); end
        else if (got_rx[0] !== 8'h3C)       begin n_err++; $display("FAIL basic_rx got %h exp 3c", got_rx[0]); end
    endtask

    task automatic test_underrun();
        int u0;
        u0 = und_cnt;
        frame_q = {8'h5A};
        send_frame();
        n_vec++; if (miso_cap[0] !== 8'hFF) begin n_err++; $display("FAIL underrun_miso got %h exp ff", miso_cap[0]); end
        n_vec++; if (und_cnt - u0 != 1)     begin n_err++; $display("FAIL underrun_pulses got %0d exp 1", und_cnt - u0); end
        drain();
        n_vec++; if (got_rx.size() != 1)    begin n_err++; $display("FAIL underrun_rx_count got %0d exp 1", got_rx.size()); end
        else if (got_rx[0] !== 8'h5A)       begin n_err++; $display("FAIL underrun_rx got %h exp 5a", got_rx[0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_tx[3];
        logic [7:0] exp_rx[3];
        exp_tx = '{8'h10, 8'h20, 8'h30};
        exp_rx = '{8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 3; i++) tx_q.push_back(exp_tx[i]);
        frame_q = {8'h01, 8'h02, 8'h03};
        send_frame();
        drain();
        n_vec++; if (got_rx.size() != 3) begin n_err++; $display("FAIL b2b_rx_count got %0d exp 3", got_rx.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (miso_cap[i] !== exp_tx[i]) begin n_err++; $display("FAIL b2b_miso[%0d] got %h exp %h", i, miso_cap[i], exp_tx[i]); end
            if (i < got_rx.size()) begin
                n_vec++; if (got_rx[i] !== exp_rx[i]) begin n_err++; $display("FAIL b2b_rx[%0d] got %h exp %h", i, got_rx[i], exp_rx[i]); end
            end
        end
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ovr_cnt;
        frame_q = {8'h81, 8'h42, 8'h24, 8'h18, 8'hE7};
        send_frame();
        n_vec++; if (ovr_cnt - o0 != 1) begin n_err++; $display("FAIL overrun_pulses got %0d exp 1", ovr_cnt - o0); end
        drain();
        n_vec++; if (got_rx.size() != RX_DEPTH) begin n_err++; $display("FAIL overrun_rx_count got %0d exp %0d", got_rx.size(), RX_DEPTH); end
        for (int i = 0; i < RX_DEPTH && i < got_rx.size(); i++) begin
            n_vec++; if (got_rx[i] !== frame_q[i]) begin n_err++; $display("FAIL overrun_rx[%0d] got %h exp %h", i, got_rx[i], frame_q[i]); end
        end
    endtask

    task automatic test_abort();
        logic [7:0] part;
        part = 8'hB6;
        cs_n = 1'b0;
        repeat (8) tick();
        for (int b = 7; b >= 3; b--) begin
            mosi = part[b];
            repeat (4) tick();
            sclk = 1'b1;
            repeat (4) tick();
            sclk = 1'b0;
        end
        repeat (4) tick();
        cs_n = 1'b1;
        repeat (6) tick();
        n_vec++; if (miso_oe !== 1'b0)  begin n_err++; $display("FAIL abort_miso_oe got %b exp 0", miso_oe); end
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL abort_busy got %b exp 0", busy); end
        n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL abort_rx_valid got %b exp 0", rx_valid); end
        frame_q = {8'hC3};
        send_frame();
        drain();
        n_vec++; if (got_rx.size() != 1) begin n_err++; $display("FAIL abort_rx_count got %0d exp 1", got_rx.size()); end
        else if (got_rx[0] !== 8'hC3)    begin n_err++; $display("FAIL abort_rx got %h exp c3", got_rx[0]); end
    endtask

    task automatic test_async_reset();
        frame_q = {8'h11};
        send_frame();
        cs_n = 1'b0;
        repeat (8) tick();
        tx_q.push_back(8'h99);
        for (int b = 7; b >= 5; b--) begin
            mosi = 1'b1;
            repeat (4) tick();
            sclk = 1'b1;
            repeat (4) tick();
            sclk = 1'b0;
        end
        mosi = 1'b0;
        repeat (4) tick();
        sclk = 1'b1;
        repeat (2) tick();
        n_vec++; if (busy !== 1'b1)     begin n_err++; $display("FAIL ares_pre_busy got %b exp 1", busy); end
        n_vec++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL ares_pre_tx_ready got %b exp 0", tx_ready); end
        n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ares_pre_rx_valid got %b exp 1", rx_valid); end
        reset = 1'b1;
        #1;
        n_vec++; if (miso !== 1'b0)     begin n_err++; $display("FAIL ares_miso got %b exp 0", miso); end
        n_vec++; if (miso_oe !== 1'b0)  begin n_err++; $display("FAIL ares_miso_oe got %b exp 0", miso_oe); end
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL ares_busy got %b exp 0", busy); end
        n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL ares_tx_ready got %b exp 1", tx_ready); end
        n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ares_rx_valid got %b exp 0", rx_valid); end
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();
        tx_q.push_back(8'h55);
        frame_q = {8'h77};
        send_frame();
        n_vec++; if (miso_cap[0] !== 8'h55) begin n_err++; $display("FAIL ares_miso_after got %h exp 55", miso_cap[0]); end
        drain();
        n_vec++; if (got_rx.size() != 1) begin n_err++; $display("FAIL ares_rx_count got %0d exp 1", got_rx.size()); end
        else if (got_rx[0] !== 8'h77)    begin n_err++; $display("FAIL ares_rx got %h exp 77", got_rx[0]); end
    endtask

    // Model: word j returns the j-th supplied TX byte or the dummy; FIFO keeps the first RX_DEPTH words.
    task automatic test_random();
        int n, k, u0, o0, exp_ovr;
        logic [7:0] txw[$];
        logic [7:0] exp_miso[$];
        logic [7:0] exp_rx[$];
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 5);
            k = $urandom_range(0, n);
            frame_q.delete();
            txw.delete();
            exp_miso.delete();
            exp_rx.delete();
            for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
            for (int i = 0; i < k; i++) txw.push_back(8'($urandom_range(0, 255)));
            for (int i = 0; i < n; i++) exp_miso.push_back(i < k ? txw[i] : 8'hFF);
            for (int i = 0; i < n && i < RX_DEPTH; i++) exp_rx.push_back(frame_q[i]);
            exp_ovr = (n > RX_DEPTH) ? n - RX_DEPTH : 0;
            for (int i = 0; i < k; i++) tx_q.push_back(txw[i]);
            u0 = und_cnt;
            o0 = ovr_cnt;
            send_frame();
            drain();
            n_vec++; if (und_cnt - u0 != n - k)   begin n_err++; $display("FAIL rnd%0d_underrun got %0d exp %0d", f, und_cnt - u0, n - k); end
            n_vec++; if (ovr_cnt - o0 != exp_ovr) begin n_err++; $display("FAIL rnd%0d_overrun got %0d exp %0d", f, ovr_cnt - o0, exp_ovr); end
            n_vec++; if (got_rx.size() != exp_rx.size()) begin n_err++; $display("FAIL rnd%0d_rx_count got %0d exp %0d", f, got_rx.size(), exp_rx.size()); end
            for (int i = 0; i < n; i++) begin
                n_vec++; if (miso_cap[i] !== exp_miso[i]) begin n_err++; $display("FAIL rnd%0d_miso[%0d] got %h exp %h", f, i, miso_cap[i], exp_miso[i]); end
            end
            for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++) begin
                n_vec++; if (got_rx[i] !== exp_rx[i]) begin n_err++; $display("FAIL rnd%0d_rx[%0d] got %h exp %h", f, i, got_rx[i], exp_rx[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
